// File: rtl/jtframe_i2s_tx_if.sv
// Sample hand-off between an audio producer and jtframe_i2s_tx.
// The producer writes CH packed samples and observes the frame/flag pulses.
interface jtframe_i2s_tx_if #(
  parameter int DW = 16,
  parameter int CH = 2
);
  logic [CH*DW-1:0] din;
  logic             din_we;
  logic [1:0]       att;
  logic             frame_st;
  logic             urun;
  logic             ovr;

  modport master (
    output din, din_we, att,
    input  frame_st, urun, ovr
  );

  modport slave (
    input  din, din_we, att,
    output frame_st, urun, ovr
  );
endinterface

// File: rtl/jtframe_i2s_tx.sv
// Parametrised I2S / left-justified / TDM serial audio transmitter.
// BCLK and LRCLK are divided down from clk; samples are sent MSB first per slot.
module jtframe_i2s_tx #(
  parameter int DW       = 16,
  parameter int CH       = 2,
  parameter int SLOTW    = 16,
  parameter int BCLK_DIV = 8,
  parameter int MODE     = 0
)(
  input  logic               clk,
  input  logic               rst,
  jtframe_i2s_tx_if.slave    aud,
  output logic               bclk,
  output logic               lrclk,
  output logic               sdata
);
  localparam int FW = CH*SLOTW;
  localparam int BW = $clog2(FW);
  localparam int CW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BCLK_DIV-1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FW-1);

  function automatic logic [DW-1:0] attenuate(input logic [DW-1:0] smp, input logic [1:0] sh);
    return $signed(smp) >>> sh;
  endfunction

  // Slot 0 sits at the MSB end so the frame leaves the top of the shift register first.
  function automatic logic [FW-1:0] pack_frame(input logic [CH*DW-1:0] smp, input logic [1:0] sh);
    logic [FW-1:0] f;
    f = '0;
    for (int c = 0; c < CH; c++) begin
      f[FW-1-c*SLOTW -: DW] = attenuate(smp[c*DW +: DW], sh);
    end
    return f;
  endfunction

  logic [CW-1:0]    cnt_r;
  logic             bclk_r;
  logic [BW-1:0]    bitcnt_r;
  logic [FW-1:0]    sr_r;
  logic [CH*DW-1:0] hold_r;
  logic             dly_r, sdata_r, lrclk_r;
  logic             fresh_r, frame_st_r, urun_r, ovr_r;

  logic             fall_s, load_s, stream_s, lr_nxt_s;
  logic [BW-1:0]    bit_nxt_s;
  logic [CH*DW-1:0] src_s;
  logic [FW-1:0]    sr_nxt_s;

  // Tick decode, next bit position and next shift-register contents
  always_comb begin
    fall_s = (cnt_r == CNT_LAST) && bclk_r;
    load_s = fall_s && (bitcnt_r == BIT_LAST);
    if (bitcnt_r == BIT_LAST) begin
      bit_nxt_s = '0;
    end else begin
      bit_nxt_s = bitcnt_r + BW'(1);
    end
    // a write coinciding with the load goes straight into the frame
    if (aud.din_we) begin
      src_s = aud.din;
    end else begin
      src_s = hold_r;
    end
    // rotating is harmless: every frame is reloaded before a wrapped bit reaches the top
    if (load_s) begin
      sr_nxt_s = pack_frame(src_s, aud.att);
    end else begin
      sr_nxt_s = {sr_r[FW-2:0], sr_r[FW-1]};
    end
    stream_s = sr_nxt_s[FW-1];
    if (CH == 2) begin
      lr_nxt_s = (bit_nxt_s >= BW'(SLOTW));
    end else begin
      lr_nxt_s = (bit_nxt_s == '0);
    end
  end

  // BCLK divider
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r  <= '0;
      bclk_r <= 1'b0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r  <= '0;
      bclk_r <= ~bclk_r;
    end else begin
      cnt_r  <= cnt_r + CW'(1);
    end
  end

  // Serialiser: bit counter, shift register, data and word-select on falling ticks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitcnt_r <= BIT_LAST;
      sr_r     <= '0;
      dly_r    <= 1'b0;
      sdata_r  <= 1'b0;
      lrclk_r  <= 1'b0;
    end else if (fall_s) begin
      bitcnt_r <= bit_nxt_s;
      sr_r     <= sr_nxt_s;
      dly_r    <= stream_s;
      sdata_r  <= (MODE == 1) ? stream_s : dly_r;
      lrclk_r  <= lr_nxt_s;
    end
  end

  // Sample hand-off: hold register, freshness and status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_r     <= '0;
      fresh_r    <= 1'b0;
      frame_st_r <= 1'b0;
      urun_r     <= 1'b0;
      ovr_r      <= 1'b0;
    end else begin
      frame_st_r <= load_s;
      urun_r     <= load_s && !fresh_r && !aud.din_we;
      ovr_r      <= aud.din_we && fresh_r && !load_s;
      if (aud.din_we) begin
        hold_r <= aud.din;
      end
      if (load_s) begin
        fresh_r <= 1'b0;
      end else if (aud.din_we) begin
        fresh_r <= 1'b1;
      end
    end
  end

  assign bclk         = bclk_r;
  assign lrclk        = lrclk_r;
  assign sdata        = sdata_r;
  assign aud.frame_st = frame_st_r;
  assign aud.urun     = urun_r;
  assign aud.ovr      = ovr_r;
endmodule

// File: doc/jtframe_i2s_tx.md
Name: jtframe_i2s_tx

Overview:
- Parametrised serial audio transmitter that replaces the fixed 16-bit stereo I2S output block on boards with an external DAC.
- Generates BCLK and LRCLK/frame-sync from the system clock by integer division and serialises CH channels of DW-bit samples, MSB first.
- Supports I2S (one-bit delay) and left-justified modes, 2-channel and TDM framing, and per-frame arithmetic attenuation.
- Flags underrun and overrun of the sample hand-off.

Parameters:
- DW, 16: sample width in bits (signed two's complement).
- CH, 2: channels per frame. Legal values 2, 4, 8.
- SLOTW, 16: bits per channel slot. Must be ≥ DW; the slot is zero-padded after the LSB.
- BCLK_DIV, 8: clk cycles per BCLK half-period. Must be ≥ 2.
- MODE, 0: 0 = I2S (data delayed one BCLK from frame edge), 1 = left-justified.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, asynchronous, active-high.
- din, input, CH*DW: packed samples; channel 0 in bits [DW-1:0].
- din_we, input, 1: one-clk strobe that latches din into the hold register.
- att, input, 2: attenuation, arithmetic right shift 0..3.
- bclk, output, 1: bit clock.
- lrclk, output, 1: word select (CH=2) or frame-sync pulse (CH>2).
- sdata, output, 1: serial data. Changes on BCLK falling edge.
- frame_st, output, 1: one-clk pulse at each frame load.
- urun, output, 1: one-clk pulse when a frame loads without a new din_we since the previous load.
- ovr, output, 1: one-clk pulse on a din_we that arrives while the hold register already contains an unconsumed sample.

Behaviour:
- Reset values: bclk, lrclk, sdata, frame_st, urun, ovr = 0. Hold register = 0, shift register = 0, divider cnt = 0, bit counter = CH*SLOTW-1, I2S delay flop = 0, fresh flag = 0.
- Divider:
  - If cnt == BCLK_DIV-1: cnt ← 0 and bclk toggles. Otherwise cnt increments.
  - BCLK period = 2*BCLK_DIV clk.
  - Falling tick = (cnt == BCLK_DIV-1 && bclk == 1).
- Bit counter:
  - Advances on each falling tick and wraps from CH*SLOTW-1 to 0.
  - Slot s = bitcnt/SLOTW; position p = bitcnt%SLOTW.
- Frame load, on the falling tick where bitcnt wraps to 0:
  - Each channel's sample is arithmetic-shifted right by att (sign-extended, att sampled this cycle) and loaded into the shift register.
  - frame_st pulses in the same clk.
  - If fresh == 0, urun pulses. fresh is cleared.
- din_we:
  - Writes hold ← din and sets fresh.
  - If fresh is already 1 and no frame load occurs in that clk, ovr pulses.
  - din_we in the same clk as a frame load: the new din bypasses into the shift register, fresh ends cleared, and neither urun nor ovr pulses.
- Stream bit for (s, p): sample[s][DW-1-p] when p < DW, else 0.
- sdata:
  - MODE 1: stream bit registered on the falling tick.
  - MODE 0: the previous stream bit, via a one-bit delay updated on each falling tick. The first bit of a frame is therefore the last bit of the previous frame.
- lrclk, updated on the falling tick:
  - CH = 2: 0 while the new bitcnt is in slot 0, 1 in slot 1. In MODE 0 this aligns with the frame edge and the data lags by one bit, per the I2S standard.
  - CH > 2: 1 only while the new bitcnt == 0, giving a one-BCLK frame-sync pulse; 0 otherwise.
- The first falling tick after reset release happens at the 2*BCLK_DIV-th clk edge. It is a frame load, so sdata carries zeros for the first frame unless din_we precedes it.
- Reset asserted mid-frame returns all state to reset values immediately. No partial frame resumes.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
- Defaults with BCLK_DIV=4, reset release → bclk toggles every 4 clk; first frame_st at clk edge 8; urun pulses with it; next frame_st after 256 clk.
- Hold din={16'h8001,16'h7FFE} written before a load, MODE 1, att=0 → slot 0 sdata 0111_1111_1111_1110, slot 1 1000_0000_0000_0001, lrclk 0 then 1; no urun.
- Same data, MODE 0 → identical bit sequence delayed one BCLK; the first bit of the frame equals the LSB of the previous frame's slot 1.
- att=2, ch0=16'h8000 → slot 0 serialises 16'hE000; att=3, ch0=16'h0010 → 16'h0002.
- CH=4, SLOTW=32, DW=24 → lrclk high for exactly one BCLK per 128-bit frame; bits 24..31 of each slot are 0.
- Two din_we in one frame → ovr on the second. din_we coincident with a load → no ovr, no urun, and the new data is serialised. Reset asserted mid-slot → bclk, lrclk, sdata 0 in the same clk.
